bist_sequencer: RTL and testbench

BIST_SEQUENCER -- requirements
Module: bist_sequencer

---
 rtl/bist_sequencer_if.sv | 35 +++
 rtl/bist_sequencer.sv | 152 +++++++++++++++
 tb/tb_bist_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bist_sequencer_if.sv
// ---------------------------------------------------------------------------
// bist_sequencer_if
// Bundles the BIST controller's request/status signals.
//   start      : run request, level-sampled (master -> slave)
//   abort      : abort a run in progress (master -> slave)
//   signature  : 8-bit MISR signature to judge (master -> slave)
//   running    : run in progress, steers the functional/LFSR input mux
//   lfsr_load  : one-cycle LFSR seed load pulse
//   misr_clear : one-cycle MISR clear pulse
//   scan_en    : 1 = scan shift, 0 = functional capture
//   bist_end   : run complete
//   pass_fail  : signature verdict, 1 = pass
// The slave modport is the sequencer; the master modport is its user.
// ---------------------------------------------------------------------------
interface bist_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] signature;
    logic       running;
    logic       lfsr_load;
    logic       misr_clear;
    logic       scan_en;
    logic       bist_end;
    logic       pass_fail;

    modport master (
        output start, abort, signature,
        input  running, lfsr_load, misr_clear, scan_en, bist_end, pass_fail
    );

    modport slave (
        input  start, abort, signature,
        output running, lfsr_load, misr_clear, scan_en, bist_end, pass_fail
    );
endinterface

// File: rtl/bist_sequencer.sv
// ---------------------------------------------------------------------------
// bist_sequencer
// Logic-BIST run controller: seeds the LFSR, shifts CHAIN_LEN bits per
// pattern, captures NUM_PATTERNS times, unloads the final capture into the
// MISR and compares the signature against SIGNATURE_VALID.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : bist_sequencer_if.slave (start/abort/signature in,
//           running/lfsr_load/misr_clear/scan_en/bist_end/pass_fail out)
// Every output is a flop; its D input is decoded from the next state so the
// outputs line up with the state they describe.
// ---------------------------------------------------------------------------
module bist_sequencer #(
    parameter int unsigned CHAIN_LEN       = 4,
    parameter int unsigned NUM_PATTERNS    = 8,
    parameter logic [7:0]  SIGNATURE_VALID = 8'h27
) (
    input  logic           clock,
    input  logic           reset,
    bist_sequencer_if.slave bus
);
    localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PAT_W   = $clog2(NUM_PATTERNS + 1);
    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
    logic               running_q, running_d;
    logic               lfsr_load_q, lfsr_load_d;
    logic               misr_clear_q, misr_clear_d;
    logic               scan_en_q, scan_en_d;
    logic               bist_end_q, bist_end_d;
    logic               pass_fail_q, pass_fail_d;
    logic               active;

    // Abort is honoured only while a run is actually in flight.
    assign active = (state_q inside {S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE});

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = '0;
        pat_cnt_d   = '0;
        pass_fail_d = pass_fail_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                pat_cnt_d = pat_cnt_q;
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                pat_cnt_d = pat_cnt_q + 1'b1;
                // pat_cnt_q still holds the count before this capture.
                state_d   = (pat_cnt_q == PAT_LAST) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                pat_cnt_d = pat_cnt_q;
                if (shift_cnt_q == SHIFT_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            S_COMPARE: begin
                pass_fail_d = (bus.signature == SIGNATURE_VALID);
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the run was about to do.
        if (bus.abort && active) begin
            state_d     = S_IDLE;
            shift_cnt_d = '0;
            pat_cnt_d   = '0;
            pass_fail_d = 1'b0;
        end

        // A new run discards the previous verdict from its first cycle.
        if (state_d == S_INIT) begin
            pass_fail_d = 1'b0;
        end

        running_d    = (state_d inside {S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE});
        lfsr_load_d  = (state_d == S_INIT);
        misr_clear_d = (state_d == S_INIT);
        scan_en_d    = (state_d inside {S_SHIFT, S_UNLOAD});
        bist_end_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_cnt_q  <= '0;
            pat_cnt_q    <= '0;
            running_q    <= 1'b0;
            lfsr_load_q  <= 1'b0;
            misr_clear_q <= 1'b0;
            scan_en_q    <= 1'b0;
            bist_end_q   <= 1'b0;
            pass_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            pat_cnt_q    <= pat_cnt_d;
            running_q    <= running_d;
            lfsr_load_q  <= lfsr_load_d;
            misr_clear_q <= misr_clear_d;
            scan_en_q    <= scan_en_d;
            bist_end_q   <= bist_end_d;
            pass_fail_q  <= pass_fail_d;
        end
    end

    assign bus.running    = running_q;
    assign bus.lfsr_load  = lfsr_load_q;
    assign bus.misr_clear = misr_clear_q;
    assign bus.scan_en    = scan_en_q;
    assign bus.bist_end   = bist_end_q;
    assign bus.pass_fail  = pass_fail_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bist_sequencer
// Drives two sequencers from the same start/abort/signature stimulus: one at
// the default geometry (4-flop chain, 8 patterns) and one at the minimum
// geometry (1-flop chain, 1 pattern). Each cycle's outputs are compared with
// a per-cycle expectation built from the run's phase lengths.
// Output vector order: {running, lfsr_load, misr_clear, scan_en, bist_end,
// pass_fail}.
// ---------------------------------------------------------------------------
module tb_bist_sequencer;
    localparam logic [7:0] GOLD = 8'h27;
    localparam int A_CL = 4;
    localparam int A_NP = 8;
    localparam int B_CL = 1;
    localparam int B_NP = 1;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] signature;

    int n_checks;
    int n_pass;

    bist_sequencer_if a_if ();
    bist_sequencer_if b_if ();

    assign a_if.start     = start;
    assign a_if.abort     = abort;
    assign a_if.signature = signature;
    assign b_if.start     = start;
    assign b_if.abort     = abort;
    assign b_if.signature = signature;

    bist_sequencer #(
        .CHAIN_LEN(A_CL), .NUM_PATTERNS(A_NP), .SIGNATURE_VALID(GOLD)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (a_if)
    );

    bist_sequencer #(
        .CHAIN_LEN(B_CL), .NUM_PATTERNS(B_NP), .SIGNATURE_VALID(GOLD)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (b_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [5:0] outs_a;
    logic [5:0] outs_b;
    assign outs_a = {a_if.running, a_if.lfsr_load, a_if.misr_clear,
                     a_if.scan_en, a_if.bist_end, a_if.pass_fail};
    assign outs_b = {b_if.running, b_if.lfsr_load, b_if.misr_clear,
                     b_if.scan_en, b_if.bist_end, b_if.pass_fail};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs in cycle c of a run (cycle 1 follows the edge that
    // samples start). A run is INIT, np x (cl shifts + 1 capture), cl unload
    // cycles, one compare, then DONE. Abort during those active cycles drops
    // straight to idle with a cleared verdict. start is high in cycles
    // 1..hold_until and sampled at the end of each cycle.
    function automatic logic [5:0] model(input int cl, input int np, input int c,
                                         input logic [7:0] sig, input int abort_at,
                                         input int hold_until);
        int active_len;
        int body_len;
        int k;
        int last_done;
        logic run_o, ld, clr, se, be, pf;
        active_len = 1 + np * (cl + 1) + cl + 1;
        body_len   = np * (cl + 1);
        run_o = 1'b0; ld = 1'b0; clr = 1'b0; se = 1'b0; be = 1'b0; pf = 1'b0;
        if (abort_at >= 1 && abort_at <= active_len && c > abort_at) begin
            return 6'b0;
        end
        if (c <= active_len) begin
            run_o = 1'b1;
            if (c == 1) begin
                ld  = 1'b1;
                clr = 1'b1;
            end else begin
                k = c - 2;
                if (k < body_len) begin
                    se = ((k % (cl + 1)) != cl);
                end else if (k < body_len + cl) begin
                    se = 1'b1;
                end else begin
                    se = 1'b0;
                end
            end
        end else begin
            pf        = (sig == GOLD);
            last_done = (hold_until >= active_len + 1) ? hold_until + 1 : active_len + 1;
            be        = (c <= last_done);
        end
        return {run_o, ld, clr, se, be, pf};
    endfunction

    task automatic do_run(input logic [7:0] sig, input int abort_at, input int hold_until);
        int end_c;
        int a_done;
        a_done = 1 + A_NP * (A_CL + 1) + A_CL + 2;
        end_c  = ((hold_until + 1 > a_done) ? hold_until + 1 : a_done) + 3;
        @(negedge clock);
        signature = sig;
        start     = 1'b1;
        abort     = 1'b0;
        @(posedge clock);
        for (int c = 1; c <= end_c; c++) begin
            #1;
            start = (c <= hold_until);
            abort = (c == abort_at);
            @(negedge clock);
            check_eq($sformatf("A sig=%0h ab=%0d hold=%0d c=%0d", sig, abort_at, hold_until, c),
                     {26'd0, outs_a}, {26'd0, model(A_CL, A_NP, c, sig, abort_at, hold_until)});
            check_eq($sformatf("B sig=%0h ab=%0d hold=%0d c=%0d", sig, abort_at, hold_until, c),
                     {26'd0, outs_b}, {26'd0, model(B_CL, B_NP, c, sig, abort_at, hold_until)});
            @(posedge clock);
        end
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic reset_mid_run();
        @(negedge clock);
        signature = GOLD;
        start     = 1'b1;
        abort     = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (29) @(posedge clock);
        #1;
        check_eq("A before reset c=30", {26'd0, outs_a},
                 {26'd0, model(A_CL, A_NP, 30, GOLD, 0, 0)});
        #1 reset = 1'b1;
        #1;
        check_eq("A async reset", {26'd0, outs_a}, 32'd0);
        check_eq("B async reset", {26'd0, outs_b}, 32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq($sformatf("A no resume %0d", i), {26'd0, outs_a}, 32'd0);
            check_eq($sformatf("B no resume %0d", i), {26'd0, outs_b}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0] rsig;
        int         rab;
        int         rhold;
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        signature = 8'h00;
        #1;
        check_eq("A reset state", {26'd0, outs_a}, 32'd0);
        check_eq("B reset state", {26'd0, outs_b}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq($sformatf("A idle after reset %0d", i), {26'd0, outs_a}, 32'd0);
            check_eq($sformatf("B idle after reset %0d", i), {26'd0, outs_b}, 32'd0);
        end

        do_run(GOLD, 0, 0);
        do_run(8'h26, 0, 0);
        do_run(8'h01, 0, 0);
        do_run(GOLD, 0, 55);
        do_run(GOLD, 20, 0);
        do_run(GOLD, 0, 0);
        do_run(GOLD, 47, 0);
        do_run(GOLD, 1, 0);
        do_run(GOLD, 46, 0);
        reset_mid_run();
        do_run(GOLD, 0, 0);

        for (int r = 0; r < 8; r++) begin
            rsig = ($urandom_range(0, 1) == 0) ? GOLD : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                rab   = $urandom_range(1, 50);
                rhold = 0;
            end else begin
                rab   = 0;
                rhold = $urandom_range(0, 60);
            end
            do_run(rsig, rab, rhold);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
